cavlc_coeff_reconstruct: RTL and testbench
==========================================

Name: cavlc_coeff_reconstruct

Overview:
- Downstream of the CAVLC level decoder and the run_before decoder in the residual path.
- Collects the signed levels (arriving highest-frequency first) and the run_before values for one block.
- Places each level at its zigzag scan position using TotalZeros, then streams the full block of coefficients in scan order to the inverse-scan/dequant stage with a valid/ready handshake.

Parameters:
- LEVEL_W, 13, width of the signed level and coefficient values.
- MAX_COEFF, 16, block size: 16 for luma 4x4, 4 for chroma DC. Legal values are 4 and 16 only.

Ports:
- Clk  in  1  clock.
- nReset  in  1  asynchronous active-low reset.
- Start  in  1  pulse. Latches TotalCoeff and TotalZeros and begins a new block; aborts any block in progress.
- TotalCoeff  in  5  number of nonzero coefficients, 0..MAX_COEFF.
- TotalZeros  in  4  zeros before the last nonzero coefficient.
- LevelIn  in  LEVEL_W  signed level, two's complement.
- LevelWr  in  1  LevelIn valid for one cycle.
- RunIn  in  4  run_before value.
- RunWr  in  1  RunIn valid for one cycle.
- CoeffOut  out  LEVEL_W  coefficient at scan index CoeffIdx.
- CoeffIdx  out  4  scan index.
- CoeffValid  out  1  output valid.
- CoeffReady  in  1  downstream accept.
- CoeffLast  out  1  high with the final index (MAX_COEFF-1).
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle pulse after the last coefficient is accepted.
- Err  out  1  sticky protocol error; cleared by Start.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0, coefficient array cleared.
- FSM states: IDLE, COLLECT, PLACE, EMIT, DONE.
- IDLE -> COLLECT on Start.
  - Start clears the coefficient array.
  - Start loads ZerosLeft = TotalZeros, LvlCnt = 0, RunCnt = 0.
  - If TotalCoeff == 0, go directly to EMIT and output all zeros.
- COLLECT:
  - LevelWr writes LevelBuf[LvlCnt] and increments LvlCnt. Index 0 is the highest-frequency coefficient.
  - RunWr writes RunBuf[RunCnt], increments RunCnt and subtracts RunIn from ZerosLeft.
  - Runs not received are treated as 0.
  - LevelWr and RunWr in the same cycle are both accepted.
  - Exit to PLACE when LvlCnt == TotalCoeff AND (RunCnt == TotalCoeff-1 OR ZerosLeft == 0). The evaluation uses the updated counts, so the transition happens on the cycle after the final write.
- PLACE (one coefficient per cycle, index i = 0..TotalCoeff-1):
  - Initial Pos = TotalCoeff + TotalZeros - 1 (6-bit arithmetic).
  - Write Coeff[Pos] = LevelBuf[i].
  - For i < TotalCoeff-1: Pos -= 1 + RunBuf[i].
  - The last coefficient uses the remaining ZerosLeft as its implicit run and needs no subtraction.
  - Duration is exactly TotalCoeff cycles, then go to EMIT.
- EMIT:
  - CoeffValid high with CoeffIdx = k, k = 0..MAX_COEFF-1.
  - k advances only when CoeffValid && CoeffReady.
  - CoeffOut, CoeffIdx and CoeffLast hold stable while CoeffValid is high and CoeffReady is low.
  - CoeffLast is high when k == MAX_COEFF-1.
  - The accepting handshake on the last index goes to DONE.
- DONE: Done = 1 for one cycle, then IDLE.
- Err is set (and the block continues) when any of the following occurs:
  - TotalCoeff + TotalZeros > MAX_COEFF at Start.
  - RunIn > ZerosLeft; ZerosLeft saturates at 0.
  - LevelWr when LvlCnt == TotalCoeff; the write is dropped.
  - RunWr when RunCnt == TotalCoeff-1; the write is dropped.
  - LevelWr or RunWr outside COLLECT; the write is ignored.
- Out-of-range Pos: if Pos >= MAX_COEFF or underflows, the write is suppressed and Err is set.
- Start in any state restarts cleanly at COLLECT. No Done is generated for the aborted block.
- Throughput: COLLECT length plus TotalCoeff plus MAX_COEFF (with CoeffReady constantly high) plus 1 cycle.

Decomposition:
- Shared package cavlc_pkg holds:
  - the state typedef;
  - LEVEL_W;
  - the MAX_COEFF_LUMA = 16 and MAX_COEFF_CDC = 4 constants.
- Sub-module cavlc_coeff_ram: MAX_COEFF x LEVEL_W register array with a clear-all input, one write port and one read port.

Test Plan:
- Nominal block. Start with TotalCoeff=5, TotalZeros=3. Send levels 1, -1, -1, 1, 3 and runs 1, 0, 0, 1. Required output on idx 0..15: 0,3,0,1,-1,-1,0,1 followed by zeros; CoeffLast at idx 15; Done one cycle after that accept.
- Early ZerosLeft exit. TotalCoeff=3, TotalZeros=2; levels 5, -2, 7; runs 2. Required: PLACE entered without further runs; output 7,-2,0,0,5 followed by zeros.
- Empty and full blocks.
  - TotalCoeff=0 -> 16 zeros and Done, with no level or run writes.
  - TotalCoeff=16, TotalZeros=0, levels 16..1 -> output 1..16 in scan order.
- Backpressure. Run the nominal block with CoeffReady toggling 1,0,0,1,... Required: no lost or duplicated index; CoeffOut and CoeffIdx stable while stalled.
- Errors.
  - Run 4 sent with ZerosLeft=3 -> Err set.
  - 6th level sent with TotalCoeff=5 -> write dropped, Err set.
  - A subsequent Start clears Err.
- Abort and reset.
  - Start mid-EMIT -> restart at COLLECT with no Done for the aborted block.
  - nReset mid-PLACE -> all outputs 0 and FSM in IDLE.
- MAX_COEFF=4. TotalCoeff=2, TotalZeros=1; levels -3, 2; runs 1. Required output 2,0,-3,0; CoeffLast at idx 3.

Source files
------------

// File: rtl/cavlc_coeff_reconstruct_pkg.sv
// Shared state encoding and size constants for CAVLC coefficient reconstruction.
package cavlc_pkg;
  localparam int LEVEL_W        = 13;
  localparam int MAX_COEFF_LUMA = 16;
  localparam int MAX_COEFF_CDC  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PLACE,
    ST_EMIT,
    ST_DONE
  } cavlc_state_e;
endpackage

// File: rtl/cavlc_coeff_reconstruct_if.sv
// Block-level bus: level/run collection inputs, coefficient stream out, status.
interface cavlc_coeff_reconstruct_if #(
  parameter int LEVEL_W = cavlc_pkg::LEVEL_W
);
  logic                      Start;
  logic [4:0]                TotalCoeff;
  logic [3:0]                TotalZeros;
  logic signed [LEVEL_W-1:0] LevelIn;
  logic                      LevelWr;
  logic [3:0]                RunIn;
  logic                      RunWr;
  logic signed [LEVEL_W-1:0] CoeffOut;
  logic [3:0]                CoeffIdx;
  logic                      CoeffValid;
  logic                      CoeffReady;
  logic                      CoeffLast;
  logic                      Busy;
  logic                      Done;
  logic                      Err;

  modport master (
    output Start, TotalCoeff, TotalZeros, LevelIn, LevelWr, RunIn, RunWr, CoeffReady,
    input  CoeffOut, CoeffIdx, CoeffValid, CoeffLast, Busy, Done, Err
  );

  modport slave (
    input  Start, TotalCoeff, TotalZeros, LevelIn, LevelWr, RunIn, RunWr, CoeffReady,
    output CoeffOut, CoeffIdx, CoeffValid, CoeffLast, Busy, Done, Err
  );
endinterface

// File: rtl/cavlc_coeff_ram.sv
// Coefficient store with clear-all, one write port and a write-first registered read.
module cavlc_coeff_ram #(
  parameter int LEVEL_W = 13,
  parameter int DEPTH   = 16,
  parameter int AW      = 4
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic                      clr_i,
  input  logic                      we_i,
  input  logic [AW-1:0]             wr_addr_i,
  input  logic signed [LEVEL_W-1:0] wr_data_i,
  input  logic [AW-1:0]             rd_addr_i,
  output logic signed [LEVEL_W-1:0] rd_data_o
);
  logic signed [LEVEL_W-1:0] mem_q [DEPTH];
  logic signed [LEVEL_W-1:0] rd_q;

  // Bypass lets the final placement write be visible on the very next read.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q <= '0;
    end else begin
      if (we_i) mem_q[wr_addr_i] <= wr_data_i;
      rd_q <= (we_i && wr_addr_i == rd_addr_i) ? wr_data_i : mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;
endmodule

// File: rtl/cavlc_coeff_reconstruct.sv
// Collects CAVLC levels and run_before values, places them at scan positions
// using TotalZeros, then streams the whole block out in scan order.
module cavlc_coeff_reconstruct #(
  parameter int LEVEL_W   = cavlc_pkg::LEVEL_W,
  parameter int MAX_COEFF = cavlc_pkg::MAX_COEFF_LUMA
) (
  input logic Clk,
  input logic nReset,
  cavlc_coeff_reconstruct_if.slave bus
);
  import cavlc_pkg::cavlc_state_e;
  import cavlc_pkg::ST_IDLE;
  import cavlc_pkg::ST_COLLECT;
  import cavlc_pkg::ST_PLACE;
  import cavlc_pkg::ST_EMIT;
  import cavlc_pkg::ST_DONE;
  import cavlc_pkg::MAX_COEFF_CDC;

  localparam int         AW       = (MAX_COEFF == MAX_COEFF_CDC) ? 2 : 4;
  localparam logic [3:0] LAST_IDX = 4'(MAX_COEFF - 1);
  localparam logic [4:0] MAX_C5   = 5'(MAX_COEFF);
  localparam logic [5:0] MAX_C6   = 6'(MAX_COEFF);

  cavlc_state_e state_q, state_d;
  logic [4:0] total_coeff_q, total_coeff_d;
  logic [4:0] lvl_cnt_q, lvl_cnt_d;
  logic [4:0] run_cnt_q, run_cnt_d;
  logic [4:0] place_idx_q, place_idx_d;
  logic [3:0] zeros_left_q, zeros_left_d;
  logic [3:0] emit_idx_q, emit_idx_d;
  logic [5:0] pos_q, pos_d;
  logic       err_q, err_d;
  logic [3:0] coeff_idx_q;
  logic       coeff_valid_q, coeff_last_q, busy_q, done_q;

  logic signed [LEVEL_W-1:0] level_buf [MAX_COEFF];
  logic [3:0]                run_buf   [MAX_COEFF];

  logic                      level_we, run_we, ram_we, accept;
  logic [4:0]                tc_m1;
  logic [3:0]                place_run;
  logic [AW-1:0]             ram_ra;
  logic signed [LEVEL_W-1:0] ram_wd, ram_rd;

  assign tc_m1     = total_coeff_q - 5'd1;
  assign accept    = coeff_valid_q && bus.CoeffReady;
  // Runs that never arrived count as zero.
  assign place_run = (place_idx_q < run_cnt_q) ? run_buf[place_idx_q[AW-1:0]] : 4'd0;
  assign ram_wd    = level_buf[place_idx_q[AW-1:0]];
  assign ram_ra    = emit_idx_d[AW-1:0];

  always_comb begin
    state_d       = state_q;
    total_coeff_d = total_coeff_q;
    lvl_cnt_d     = lvl_cnt_q;
    run_cnt_d     = run_cnt_q;
    place_idx_d   = place_idx_q;
    zeros_left_d  = zeros_left_q;
    emit_idx_d    = emit_idx_q;
    pos_d         = pos_q;
    err_d         = err_q;
    level_we      = 1'b0;
    run_we        = 1'b0;
    ram_we        = 1'b0;

    if (bus.Start) begin
      total_coeff_d = bus.TotalCoeff;
      lvl_cnt_d     = '0;
      run_cnt_d     = '0;
      place_idx_d   = '0;
      emit_idx_d    = '0;
      zeros_left_d  = bus.TotalZeros;
      pos_d         = 6'(bus.TotalCoeff) + 6'(bus.TotalZeros) - 6'd1;
      err_d         = (6'(bus.TotalCoeff) + 6'(bus.TotalZeros)) > MAX_C6;
      state_d       = (bus.TotalCoeff == 5'd0) ? ST_EMIT : ST_COLLECT;
    end else begin
      if ((bus.LevelWr || bus.RunWr) && state_q != ST_COLLECT) err_d = 1'b1;

      case (state_q)
        ST_COLLECT: begin
          if (bus.LevelWr) begin
            if (lvl_cnt_q == total_coeff_q || lvl_cnt_q == MAX_C5) begin
              err_d = 1'b1;
            end else begin
              level_we  = 1'b1;
              lvl_cnt_d = lvl_cnt_q + 5'd1;
            end
          end
          if (bus.RunWr) begin
            if (run_cnt_q == tc_m1 || run_cnt_q == MAX_C5) begin
              err_d = 1'b1;
            end else begin
              run_we    = 1'b1;
              run_cnt_d = run_cnt_q + 5'd1;
              if (bus.RunIn > zeros_left_q) begin
                err_d        = 1'b1;
                zeros_left_d = '0;
              end else begin
                zeros_left_d = zeros_left_q - bus.RunIn;
              end
            end
          end
          if (lvl_cnt_d == total_coeff_q && (run_cnt_d == tc_m1 || zeros_left_d == 4'd0))
            state_d = ST_PLACE;
        end
        ST_PLACE: begin
          // Positions past the block or wrapped below zero are rejected.
          if (pos_q < MAX_C6) ram_we = 1'b1;
          else                err_d  = 1'b1;
          pos_d       = pos_q - 6'd1 - 6'(place_run);
          place_idx_d = place_idx_q + 5'd1;
          if (place_idx_q == tc_m1) state_d = ST_EMIT;
        end
        ST_EMIT: begin
          if (accept) begin
            emit_idx_d = emit_idx_q + 4'd1;
            if (emit_idx_q == LAST_IDX) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= ST_IDLE;
      total_coeff_q <= '0;
      lvl_cnt_q     <= '0;
      run_cnt_q     <= '0;
      place_idx_q   <= '0;
      zeros_left_q  <= '0;
      emit_idx_q    <= '0;
      pos_q         <= '0;
      err_q         <= 1'b0;
      coeff_idx_q   <= '0;
      coeff_valid_q <= 1'b0;
      coeff_last_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      total_coeff_q <= total_coeff_d;
      lvl_cnt_q     <= lvl_cnt_d;
      run_cnt_q     <= run_cnt_d;
      place_idx_q   <= place_idx_d;
      zeros_left_q  <= zeros_left_d;
      emit_idx_q    <= emit_idx_d;
      pos_q         <= pos_d;
      err_q         <= err_d;
      coeff_idx_q   <= (state_d == ST_EMIT) ? emit_idx_d : 4'd0;
      coeff_valid_q <= (state_d == ST_EMIT);
      coeff_last_q  <= (state_d == ST_EMIT) && (emit_idx_d == LAST_IDX);
      busy_q        <= (state_d != ST_IDLE);
      done_q        <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge Clk) begin
    if (level_we) level_buf[lvl_cnt_q[AW-1:0]] <= bus.LevelIn;
    if (run_we)   run_buf[run_cnt_q[AW-1:0]]   <= bus.RunIn;
  end

  cavlc_coeff_ram #(
    .LEVEL_W(LEVEL_W),
    .DEPTH  (MAX_COEFF),
    .AW     (AW)
  ) u_ram (
    .Clk      (Clk),
    .nReset   (nReset),
    .clr_i    (bus.Start),
    .we_i     (ram_we && !bus.Start),
    .wr_addr_i(pos_q[AW-1:0]),
    .wr_data_i(ram_wd),
    .rd_addr_i(ram_ra),
    .rd_data_o(ram_rd)
  );

  assign bus.CoeffOut   = ram_rd;
  assign bus.CoeffIdx   = coeff_idx_q;
  assign bus.CoeffValid = coeff_valid_q;
  assign bus.CoeffLast  = coeff_last_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.Err        = err_q;
endmodule

// File: tb/tb_cavlc_coeff_reconstruct.sv
// Directed bench: luma (16) and chroma DC (4) instances with hand-computed blocks.
module tb_cavlc_coeff_reconstruct;
  localparam int LW = 13;

  logic Clk = 1'b0;
  logic nReset = 1'b0;
  always #5 Clk = ~Clk;

  cavlc_coeff_reconstruct_if #(.LEVEL_W(LW)) bus16 ();
  cavlc_coeff_reconstruct_if #(.LEVEL_W(LW)) bus4 ();

  cavlc_coeff_reconstruct #(.LEVEL_W(LW), .MAX_COEFF(16)) dut16 (
    .Clk(Clk), .nReset(nReset), .bus(bus16)
  );
  cavlc_coeff_reconstruct #(.LEVEL_W(LW), .MAX_COEFF(4)) dut4 (
    .Clk(Clk), .nReset(nReset), .bus(bus4)
  );

  logic                 start = 1'b0;
  logic [4:0]           tc = '0;
  logic [3:0]           tz = '0;
  logic signed [LW-1:0] lvl = '0;
  logic                 lvl_wr = 1'b0;
  logic [3:0]           run = '0;
  logic                 run_wr = 1'b0;
  logic                 rdy = 1'b0;
  logic                 use4 = 1'b0;

  assign bus16.Start = start;   assign bus4.Start = start;
  assign bus16.TotalCoeff = tc; assign bus4.TotalCoeff = tc;
  assign bus16.TotalZeros = tz; assign bus4.TotalZeros = tz;
  assign bus16.LevelIn = lvl;   assign bus4.LevelIn = lvl;
  assign bus16.LevelWr = lvl_wr; assign bus4.LevelWr = lvl_wr;
  assign bus16.RunIn = run;     assign bus4.RunIn = run;
  assign bus16.RunWr = run_wr;  assign bus4.RunWr = run_wr;
  assign bus16.CoeffReady = rdy; assign bus4.CoeffReady = rdy;

  logic signed [LW-1:0] o_coeff;
  logic [3:0]           o_idx;
  logic                 o_valid, o_last, o_busy, o_done, o_err;
  assign o_coeff = use4 ? bus4.CoeffOut   : bus16.CoeffOut;
  assign o_idx   = use4 ? bus4.CoeffIdx   : bus16.CoeffIdx;
  assign o_valid = use4 ? bus4.CoeffValid : bus16.CoeffValid;
  assign o_last  = use4 ? bus4.CoeffLast  : bus16.CoeffLast;
  assign o_busy  = use4 ? bus4.Busy       : bus16.Busy;
  assign o_done  = use4 ? bus4.Done       : bus16.Done;
  assign o_err   = use4 ? bus4.Err        : bus16.Err;

  int n_checks = 0;
  int n_errors = 0;
  int exp_c [16];

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_block(input int c, input int z);
    start = 1'b1;
    tc = 5'(c);
    tz = 4'(z);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int lv, input bit lw, input int rv, input bit rw);
    lvl = LW'(lv);
    lvl_wr = lw;
    run = 4'(rv);
    run_wr = rw;
    tick();
    lvl_wr = 1'b0;
    run_wr = 1'b0;
  endtask

  task automatic feed_nominal();
    int lv [5] = '{1, -1, -1, 1, 3};
    int rn [4] = '{1, 0, 0, 1};
    for (int i = 0; i < 5; i++)
      send(lv[i], 1'b1, (i < 4) ? rn[i] : 0, i < 4);
  endtask

  task automatic feed_early();
    send(5, 1'b1, 2, 1'b1);
    send(-2, 1'b1, 0, 1'b0);
    send(7, 1'b1, 0, 1'b0);
  endtask

  // Accepts coefficients until 'upto' have been taken; full drains also check Done.
  task automatic drain(input string name, input int n, input int upto, input bit bp);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    int prev_out = 0;
    int prev_idx = 0;
    while (k < upto && cyc < 400) begin
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      if (o_valid) begin
        if (stalled) begin
          chk({name, " hold out"}, int'(o_coeff), prev_out);
          chk({name, " hold idx"}, int'(o_idx), prev_idx);
        end
        chk({name, " idx"}, int'(o_idx), k);
        chk($sformatf("%s out[%0d]", name, k), int'(o_coeff), exp_c[k]);
        chk($sformatf("%s last[%0d]", name, k), int'(o_last), (k == n - 1) ? 1 : 0);
        stalled = !rdy;
        prev_out = int'(o_coeff);
        prev_idx = int'(o_idx);
        if (rdy) k++;
      end
      tick();
      cyc++;
    end
    rdy = 1'b0;
    chk({name, " accepted"}, k, upto);
    if (upto == n) begin
      chk({name, " Done"}, int'(o_done), 1);
      tick();
      chk({name, " Done pulse"}, int'(o_done), 0);
      chk({name, " idle"}, int'(o_busy), 0);
    end
    $display("block %s: %0d of %0d coefficients accepted in %0d cycles", name, k, n, cyc);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst valid", int'(o_valid), 0);
    chk("rst busy", int'(o_busy), 0);
    chk("rst done", int'(o_done), 0);
    chk("rst err", int'(o_err), 0);
    chk("rst idx", int'(o_idx), 0);
    chk("rst last", int'(o_last), 0);
    chk("rst coeff", int'(o_coeff), 0);
    nReset = 1'b1;
    tick();

    // Nominal block with latency check
    exp_c = '{0, 3, 0, 1, -1, -1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    start_block(5, 3);
    chk("nom busy", int'(o_busy), 1);
    chk("nom valid early", int'(o_valid), 0);
    feed_nominal();
    repeat (4) tick();
    chk("nom place valid", int'(o_valid), 0);
    tick();
    chk("nom emit valid", int'(o_valid), 1);
    drain("nominal", 16, 16, 1'b0);

    // Same block under backpressure
    start_block(5, 3);
    feed_nominal();
    drain("backpressure", 16, 16, 1'b1);

    // Early exit on ZerosLeft reaching 0
    exp_c = '{7, -2, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    start_block(3, 2);
    feed_early();
    repeat (2) tick();
    chk("early place valid", int'(o_valid), 0);
    tick();
    chk("early emit valid", int'(o_valid), 1);
    drain("early", 16, 16, 1'b0);

    // Empty block
    exp_c = '{default: 0};
    start_block(0, 0);
    chk("empty valid", int'(o_valid), 1);
    drain("empty", 16, 16, 1'b0);

    // Full block
    for (int i = 0; i < 16; i++) exp_c[i] = i + 1;
    start_block(16, 0);
    for (int i = 0; i < 16; i++) send(16 - i, 1'b1, 0, 1'b0);
    drain("full", 16, 16, 1'b0);

    // Protocol errors
    start_block(10, 8);
    chk("err overflow", int'(o_err), 1);
    start_block(5, 3);
    chk("err cleared", int'(o_err), 0);
    send(0, 1'b0, 4, 1'b1);
    chk("err run", int'(o_err), 1);
    start_block(5, 3);
    chk("err cleared2", int'(o_err), 0);
    send(1, 1'b1, 0, 1'b0);
    send(-1, 1'b1, 0, 1'b0);
    send(-1, 1'b1, 0, 1'b0);
    send(1, 1'b1, 0, 1'b0);
    send(3, 1'b1, 0, 1'b0);
    chk("err none yet", int'(o_err), 0);
    send(9, 1'b1, 0, 1'b0);
    chk("err extra level", int'(o_err), 1);
    send(0, 1'b0, 1, 1'b1);
    send(0, 1'b0, 0, 1'b1);
    send(0, 1'b0, 0, 1'b1);
    send(0, 1'b0, 1, 1'b1);
    exp_c = '{0, 3, 0, 1, -1, -1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    drain("dropped level", 16, 16, 1'b0);
    chk("err sticky", int'(o_err), 1);

    // Abort mid-EMIT
    start_block(5, 3);
    feed_nominal();
    drain("aborted", 16, 5, 1'b0);
    start_block(3, 2);
    chk("abort valid", int'(o_valid), 0);
    chk("abort busy", int'(o_busy), 1);
    chk("abort done", int'(o_done), 0);
    exp_c = '{7, -2, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    feed_early();
    drain("after abort", 16, 16, 1'b0);

    // Reset mid-PLACE
    start_block(16, 0);
    for (int i = 0; i < 16; i++) send(16 - i, 1'b1, 0, 1'b0);
    repeat (3) tick();
    send(5, 1'b1, 0, 1'b0);
    chk("place write err", int'(o_err), 1);
    chk("place busy", int'(o_busy), 1);
    nReset = 1'b0;
    #2;
    chk("mid rst busy", int'(o_busy), 0);
    chk("mid rst err", int'(o_err), 0);
    chk("mid rst valid", int'(o_valid), 0);
    chk("mid rst done", int'(o_done), 0);
    chk("mid rst coeff", int'(o_coeff), 0);
    tick();
    nReset = 1'b1;
    tick();
    chk("post rst busy", int'(o_busy), 0);

    // Chroma DC instance
    use4 = 1'b1;
    exp_c = '{default: 0};
    exp_c[0] = 2;
    exp_c[2] = -3;
    start_block(2, 1);
    send(-3, 1'b1, 1, 1'b1);
    send(2, 1'b1, 0, 1'b0);
    drain("chroma", 4, 4, 1'b0);
    chk("chroma err", int'(o_err), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
